borrow_look_ahead_sub_seq: RTL and testbench

- Multi-cycle subtractor for the ALU datapath. Computes diff = A - B - b_in over WIDTH bits.
- Processes one 4-bit slice per cycle, LSB slice first. Each slice uses 4-bit borrow-lookahead logic: generate g_i = ~a_i & b_i, propagate p_i = ~(a_i ^ b_i).
- The slice borrow chains into the next cycle.
- Valid/ready handshake on both the operand side and the result side. One operation in flight at a time.

---
 rtl/borrow_look_ahead_sub_seq_if.sv | 26 ++
 rtl/borrow_look_ahead_sub_seq.sv | 107 ++++++++++
 tb/tb_borrow_look_ahead_sub_seq.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/borrow_look_ahead_sub_seq_if.sv
// Operand/result handshake bundle for the sequential borrow-lookahead subtractor.
interface borrow_look_ahead_sub_seq_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             b_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             b_out;
    logic             overflow;
    logic             zero;

    modport master (
        output in_valid, A, B, b_in, out_ready,
        input  in_ready, out_valid, result, b_out, overflow, zero
    );

    modport slave (
        input  in_valid, A, B, b_in, out_ready,
        output in_ready, out_valid, result, b_out, overflow, zero
    );
endinterface

// File: rtl/borrow_look_ahead_sub_seq.sv
// Multi-cycle subtractor: one 4-bit borrow-lookahead slice per cycle, LSB first.
module borrow_look_ahead_sub_seq #(
    parameter int WIDTH = 16
) (
    input logic                         clk,
    input logic                         rst,
    borrow_look_ahead_sub_seq_if.slave  bus
);
    localparam int NSLICE = WIDTH / 4;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic             bw_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic             b_out_q;
    logic             ovf_q;
    logic             zero_q;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [3:0]       a_sl;
    logic [3:0]       b_sl;
    logic [3:0]       g;
    logic [3:0]       p;
    logic [4:0]       bw;
    logic [3:0]       d;
    logic [WIDTH-1:0] res_nxt;

    always_comb begin
        a_sh = a_q >> {cnt, 2'b00};
        b_sh = b_q >> {cnt, 2'b00};
        a_sl = a_sh[3:0];
        b_sl = b_sh[3:0];
        g    = ~a_sl & b_sl;
        p    = ~(a_sl ^ b_sl);
        // Flattened lookahead: every borrow depends only on g, p and the slice borrow-in.
        bw[0] = bw_q;
        bw[1] = g[0] | (p[0] & bw_q);
        bw[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bw_q);
        bw[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & bw_q);
        bw[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & bw_q);
        d     = a_sl ^ b_sl ^ bw[3:0];
        res_nxt = res_q;
        for (int unsigned k = 0; k < NSLICE; k++) begin
            if (cnt == CW'(k)) res_nxt[4*k +: 4] = d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bw_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            b_out_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q   <= bus.A;
                        b_q   <= bus.B;
                        bw_q  <= bus.b_in;
                        cnt   <= '0;
                        res_q <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    res_q <= res_nxt;
                    bw_q  <= bw[4];
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state   <= DONE;
                        b_out_q <= bw[4];
                        ovf_q   <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (res_nxt[WIDTH-1] != a_q[WIDTH-1]);
                        zero_q  <= (res_nxt == '0);
                    end
                end
                DONE: begin
                    if (bus.out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.result    = res_q;
    assign bus.b_out     = b_out_q;
    assign bus.overflow  = ovf_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_borrow_look_ahead_sub_seq.sv
// Scoreboard bench for borrow_look_ahead_sub_seq (WIDTH=16): directed vectors plus a modelled sweep.
module tb_borrow_look_ahead_sub_seq;
    localparam int W = 16;
    localparam int NS = W / 4;

    typedef struct packed {
        logic [W-1:0] res;
        logic         bo;
        logic         ovf;
        logic         zr;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    borrow_look_ahead_sub_seq_if #(.WIDTH(W)) sub_if ();

    borrow_look_ahead_sub_seq #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sub_if)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    bit   seen = 1'b0;
    bit   rand_ready = 1'b0;
    bit   force_ready = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // out_ready changes just after the edge so the negedge monitor sees a settled value
    always @(posedge clk) begin
        #1;
        sub_if.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : force_ready;
    end

    always @(negedge clk) begin
        if (!rst && sub_if.out_valid) begin
            if (!seen) begin
                seen = 1'b1;
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("latency", 32'(cyc - acc_cyc), 32'(NS));
                    check("result", 32'(sub_if.result), 32'(e.res));
                    check("b_out", 32'(sub_if.b_out), 32'(e.bo));
                    check("overflow", 32'(sub_if.overflow), 32'(e.ovf));
                    check("zero", 32'(sub_if.zero), 32'(e.zr));
                end
            end
            if (sub_if.out_ready) seen = 1'b0;
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        input logic [W-1:0] er, input logic ebo, input logic eovf, input logic ez);
        int n;
        exp_t e;
        n = 0;
        @(negedge clk);
        sub_if.A = a;
        sub_if.B = b;
        sub_if.b_in = bin;
        sub_if.in_valid = 1'b1;
        while (!sub_if.in_ready) begin
            @(negedge clk);
            n++;
            if (n > 200) begin
                check("accept_timeout", 32'd1, 32'd0);
                sub_if.in_valid = 1'b0;
                return;
            end
        end
        e.res = er; e.bo = ebo; e.ovf = eovf; e.zr = ez;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        sub_if.in_valid = 1'b0;
    endtask

    task automatic send_model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        logic [W:0] full;
        logic [W-1:0] d;
        full = {1'b0, a} - {1'b0, b} - (W+1)'(bin);
        d = full[W-1:0];
        send(a, b, bin, d, full[W], (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]), d == '0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 || sub_if.out_valid) begin
            @(negedge clk);
            n++;
            if (n > 300) begin
                check("drain_timeout", 32'd1, 32'd0);
                return;
            end
        end
    endtask

    initial begin
        int n;
        sub_if.in_valid = 1'b0;
        sub_if.A = '0;
        sub_if.B = '0;
        sub_if.b_in = 1'b0;
        sub_if.out_ready = 1'b1;
        #1;
        check("rst_out_valid", 32'(sub_if.out_valid), 32'd0);
        check("rst_result", 32'(sub_if.result), 32'd0);
        check("rst_flags", {29'd0, sub_if.b_out, sub_if.overflow, sub_if.zero}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_in_ready", 32'(sub_if.in_ready), 32'd1);

        send(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0); drain();
        send(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0); drain();
        send(16'h0010, 16'h0000, 1'b1, 16'h000F, 1'b0, 1'b0, 1'b0); drain();
        send(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0); drain();
        send(16'h5555, 16'h5555, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1); drain();
        send(16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1); drain();
        send(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0); drain();

        // backpressure with a stray in_valid while DONE
        force_ready = 1'b0;
        send(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
        n = 0;
        while (!sub_if.out_valid && n < 50) begin @(negedge clk); n++; end
        check("bp_out_valid", 32'(sub_if.out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            sub_if.in_valid = (i == 1);
            sub_if.A = 16'hFFFF;
            sub_if.B = 16'h0001;
            @(negedge clk);
            check("bp_hold_result", 32'(sub_if.result), 32'h1000);
            check("bp_hold_valid", 32'(sub_if.out_valid), 32'd1);
            check("bp_in_ready", 32'(sub_if.in_ready), 32'd0);
        end
        sub_if.in_valid = 1'b0;
        force_ready = 1'b1;
        @(posedge clk); #2;
        @(posedge clk); #2;
        check("bp_release_in_ready", 32'(sub_if.in_ready), 32'd1);
        check("bp_release_valid", 32'(sub_if.out_valid), 32'd0);
        repeat (8) @(negedge clk);
        check("bp_no_capture", 32'(sub_if.out_valid), 32'd0);

        // reset after two slices
        send(16'hABCD, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        @(posedge clk); @(posedge clk);
        #2;
        rst = 1'b1;
        void'(exp_q.pop_back());
        #1;
        check("midrst_out_valid", 32'(sub_if.out_valid), 32'd0);
        check("midrst_result", 32'(sub_if.result), 32'd0);
        check("midrst_flags", {29'd0, sub_if.b_out, sub_if.overflow, sub_if.zero}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_in_ready", 32'(sub_if.in_ready), 32'd1);
        send(16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1); drain();

        rand_ready = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send_model(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
